chirp_seq_ctrl: RTL

- Command-driven controller in front of the chirpmod datapath.
- Receives bytes from a UART RX byte receiver and parses 4-byte command frames.
- Holds the chirp configuration registers (SF, BW, clock divider).
- Sequences bursts of chirps by pulsing start and counting the core's done strobes.

---
 rtl/chirp_ctrl_pkg.sv | 28 ++
 rtl/chirp_cmd_parser.sv | 90 +++++++++
 rtl/chirp_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/chirp_ctrl_pkg.sv
// Shared constants and state types for the chirp sequencing controller.
package chirp_ctrl_pkg;

   localparam logic [7:0] FRAME_HDR   = 8'hA5;

   localparam logic [7:0] CMD_SET_SF  = 8'h01;
   localparam logic [7:0] CMD_SET_BW  = 8'h02;
   localparam logic [7:0] CMD_SET_DIV = 8'h03;
   localparam logic [7:0] CMD_START   = 8'h04;
   localparam logic [7:0] CMD_STOP    = 8'h05;

   localparam logic [7:0] SF_MIN = 8'd7;
   localparam logic [7:0] SF_MAX = 8'd12;

   typedef enum logic [1:0] {
      P_HDR,
      P_CMD,
      P_ARG,
      P_CHK
   } parse_state_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT
   } seq_state_e;

endpackage

// File: rtl/chirp_cmd_parser.sv
// Frame parser for A5/CMD/ARG/CHK command frames arriving from the UART receiver.
//
// state | meaning
// P_HDR | hunting for the 0xA5 header, other bytes dropped
// P_CMD | header seen, next byte is the command
// P_ARG | next byte is the argument
// P_CHK | next byte is the checksum; frame is accepted or rejected on it
//
// o_cmd_valid / o_frame_err are combinational so the top can act on the very
// edge that samples the checksum byte. The inter-byte timer is a down-counter
// reloaded on every byte; reaching zero outside P_HDR abandons the frame.
module chirp_cmd_parser
   import chirp_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic       o_cmd_valid,
   output logic [7:0] o_cmd,
   output logic [7:0] o_arg,
   output logic       o_frame_err
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   parse_state_e     state_q, state_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       arg_q, arg_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   assign o_cmd = cmd_q;
   assign o_arg = arg_q;

   // Next-state, byte capture, checksum verdict and inter-byte timeout.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      arg_d       = arg_q;
      tmr_d       = tmr_q;
      o_cmd_valid = 1'b0;
      o_frame_err = 1'b0;
      if (i_rx_valid) begin
         tmr_d = TMR_LOAD;
         case (state_q)
            P_HDR: if (i_rx_data == FRAME_HDR) state_d = P_CMD;
            P_CMD: begin
               cmd_d   = i_rx_data;
               state_d = P_ARG;
            end
            P_ARG: begin
               arg_d   = i_rx_data;
               state_d = P_CHK;
            end
            P_CHK: begin
               state_d = P_HDR;
               if (i_rx_data == (FRAME_HDR ^ cmd_q ^ arg_q)) o_cmd_valid = 1'b1;
               else                                          o_frame_err = 1'b1;
            end
            default: state_d = P_HDR;
         endcase
      end else if (state_q != P_HDR) begin
         if (tmr_q == '0) begin
            state_d     = P_HDR;
            o_frame_err = 1'b1;
         end else begin
            tmr_d = tmr_q - 1'b1;
         end
      end
   end

   // Parser state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= P_HDR;
         cmd_q   <= '0;
         arg_q   <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         arg_q   <= arg_d;
         tmr_q   <= tmr_d;
      end
   end

endmodule

// File: rtl/chirp_seq_ctrl.sv
// Command decode, chirp configuration registers and burst sequencer.
//
// state   | meaning
// S_IDLE  | no burst; done edges ignored, config writable
// S_START | one-cycle start pulse to the chirp core
// S_WAIT  | chirp running, waiting for the registered done_n falling edge
module chirp_seq_ctrl
   import chirp_ctrl_pkg::*;
#(
   parameter int MAX_SF_WIDTH     = 8,
   parameter int BW_BITWIDTH      = 2,
   parameter int DIVIDER_BITWIDTH = 7,
   parameter int CNT_WIDTH        = 8,
   parameter int TIMEOUT_CYCLES   = 25000
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [7:0]                  i_rx_data,
   input  logic                        i_rx_valid,
   input  logic                        i_done_n,
   output logic                        o_start,
   output logic [MAX_SF_WIDTH-1:0]     o_sf,
   output logic [BW_BITWIDTH-1:0]      o_bw,
   output logic [DIVIDER_BITWIDTH-1:0] o_div,
   output logic                        o_busy,
   output logic [CNT_WIDTH-1:0]        o_chirp_cnt,
   output logic                        o_err
);

   logic       cmd_valid, frame_err;
   logic [7:0] cmd, arg;

   chirp_cmd_parser #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_parser (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_rx_data   (i_rx_data),
      .i_rx_valid  (i_rx_valid),
      .o_cmd_valid (cmd_valid),
      .o_cmd       (cmd),
      .o_arg       (arg),
      .o_frame_err (frame_err)
   );

   seq_state_e                  seq_q, seq_d;
   logic [MAX_SF_WIDTH-1:0]     sf_q, sf_d;
   logic [BW_BITWIDTH-1:0]      bw_q, bw_d;
   logic [DIVIDER_BITWIDTH-1:0] div_q, div_d;
   logic [CNT_WIDTH-1:0]        repeat_q, repeat_d;
   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, cnt_inc;
   logic                        stop_q, stop_d;
   logic                        done_cur_q, done_cur_d;
   logic                        done_prev_q, done_prev_d;
   logic                        err_q, err_d;
   logic                        busy, cmd_err, start_cmd, stop_cmd, done_fall;

   assign busy        = (seq_q != S_IDLE);
   assign done_fall   = done_prev_q & ~done_cur_q;
   assign o_start     = (seq_q == S_START);
   assign o_busy      = busy;
   assign o_sf        = sf_q;
   assign o_bw        = bw_q;
   assign o_div       = div_q;
   assign o_chirp_cnt = cnt_q;
   assign o_err       = err_q;

   // Command decode: config writes, burst start/stop requests and rejects.
   always_comb begin
      sf_d      = sf_q;
      bw_d      = bw_q;
      div_d     = div_q;
      cmd_err   = 1'b0;
      start_cmd = 1'b0;
      stop_cmd  = 1'b0;
      if (cmd_valid) begin
         case (cmd)
            CMD_SET_SF: begin
               if (busy || arg < SF_MIN || arg > SF_MAX) cmd_err = 1'b1;
               else                                      sf_d = MAX_SF_WIDTH'(arg);
            end
            CMD_SET_BW: begin
               if (busy || (arg >> BW_BITWIDTH) != 8'd0) cmd_err = 1'b1;
               else                                      bw_d = arg[BW_BITWIDTH-1:0];
            end
            CMD_SET_DIV: begin
               if (busy || arg[7] || arg[6:0] == 7'd0) cmd_err = 1'b1;
               else                                    div_d = arg[DIVIDER_BITWIDTH-1:0];
            end
            CMD_START: begin
               if (busy) cmd_err   = 1'b1;
               else      start_cmd = 1'b1;
            end
            CMD_STOP: stop_cmd = busy;
            default:  cmd_err  = 1'b1;
         endcase
      end
      err_d       = cmd_err | frame_err;
      done_cur_d  = i_done_n;
      done_prev_d = done_cur_q;
   end

   // Burst sequencer: start pulse, done counting, repeat/stop termination.
   always_comb begin
      seq_d    = seq_q;
      cnt_d    = cnt_q;
      repeat_d = repeat_q;
      stop_d   = stop_q | stop_cmd;
      cnt_inc  = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      case (seq_q)
         S_IDLE: begin
            if (start_cmd) begin
               seq_d    = S_START;
               cnt_d    = '0;
               stop_d   = 1'b0;
               repeat_d = CNT_WIDTH'(arg);
            end
         end
         S_START: seq_d = S_WAIT;
         S_WAIT: begin
            if (done_fall) begin
               cnt_d = cnt_inc;
               if (stop_q || stop_cmd) begin
                  seq_d  = S_IDLE;
                  stop_d = 1'b0;
               end else if (repeat_q != '0 && cnt_inc == repeat_q) begin
                  seq_d = S_IDLE;
               end else begin
                  seq_d = S_START;
               end
            end
         end
         default: seq_d = S_IDLE;
      endcase
   end

   // Config, sequencer and done-edge registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         seq_q       <= S_IDLE;
         sf_q        <= MAX_SF_WIDTH'(SF_MIN);
         bw_q        <= '0;
         div_q       <= DIVIDER_BITWIDTH'(1);
         repeat_q    <= '0;
         cnt_q       <= '0;
         stop_q      <= 1'b0;
         done_cur_q  <= 1'b1;
         done_prev_q <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         seq_q       <= seq_d;
         sf_q        <= sf_d;
         bw_q        <= bw_d;
         div_q       <= div_d;
         repeat_q    <= repeat_d;
         cnt_q       <= cnt_d;
         stop_q      <= stop_d;
         done_cur_q  <= done_cur_d;
         done_prev_q <= done_prev_d;
         err_q       <= err_d;
      end
   end

endmodule
